// File: rtl/tcount_share_arb_pkg.sv
// Shared FSM encoding and default sizing for the tcount_share_arb slice.
package tcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 3;

endpackage

// File: rtl/tcount_share_arb_core.sv
// CNT_W-bit synchronous up-counter made of per-bit T flip-flops on one clock.
// Bit i toggles when enabled and all lower bits are one; clear wins over enable.
module tcount_core
    import tcount_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)(
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_q
);

    logic [CNT_W-1:0] r_q;
    logic [CNT_W-1:0] w_t;

    always_comb begin
        logic [CNT_W-1:0] w_mask;
        w_t    = '0;
        w_mask = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            w_mask = CNT_W'((64'd1 << i) - 64'd1);
            w_t[i] = i_en & ((r_q & w_mask) == w_mask);
        end
    end

    for (genvar g = 0; g < CNT_W; g++) begin : g_tff
        always_ff @(posedge clk) begin
            if (i_clear)
                r_q[g] <= 1'b0;
            else if (w_t[g])
                r_q[g] <= ~r_q[g];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/tcount_share_arb.sv
// Round-robin sharing of one T-FF up-counter among N_REQ timed-interval requesters.
// Optional owner-abort during RUN is enabled by defining TCOUNT_SHARE_ARB_ABORT_EN.
module tcount_share_arb
    import tcount_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int IDX_W = $clog2(N_REQ)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner,
    output logic [CNT_W-1:0]       cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_win;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] w_len_win;
    logic [CNT_W-1:0] w_cnt;
    logic             w_any;
    logic             w_clear;
    logic             w_en;
    logic             w_load;
    logic             w_rr_upd;
    int unsigned      w_cand;

    // First set req bit at or above r_rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_win  = '0;
        w_any  = 1'b0;
        w_cand = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = (32'(r_rr_ptr) + k) % N_REQ;
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_win = IDX_W'(w_cand);
            end
        end
    end

    always_comb begin
        w_len_win = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_win == IDX_W'(i))
                w_len_win = len[i*CNT_W +: CNT_W];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = reset;
        w_en        = 1'b0;
        w_load      = 1'b0;
        w_rr_upd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                if (w_cnt == r_target)
                    w_state_nxt = DONE;
                else
                    w_en = 1'b1;
`ifdef TCOUNT_SHARE_ARB_ABORT_EN
                // Owner withdrawal overrides both counting and completion.
                if (!req[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_en        = 1'b0;
                    w_rr_upd    = 1'b1;
                end
`endif
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_rr_upd    = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_target <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_owner  <= w_win;
                r_target <= w_len_win;
            end
            if (w_rr_upd)
                r_rr_ptr <= (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
        end
    end

    tcount_core #(.CNT_W(CNT_W)) u_core (
        .clk     (clk),
        .i_clear (w_clear),
        .i_en    (w_en),
        .o_q     (w_cnt)
    );

    always_comb begin
        grant = '0;
        done  = '0;
        if (r_state == RUN)
            grant[r_owner] = 1'b1;
        if (r_state == DONE)
            done[r_owner] = 1'b1;
    end

    assign busy  = (r_state == RUN) || (r_state == DONE);
    assign owner = r_owner;
    assign cnt   = w_cnt;

endmodule
